// File: rtl/switch_debounce_if.sv
// ---------------------------------------------------------------------------
// switch_debounce_if
//   Bundles the switch inputs and the debounced outputs of switch_debounce.
//   master : the user side. It drives switch and receives the clean levels.
//   slave  : the debouncer side.
//   Signals:
//     switch    [WIDTH] raw asynchronous switch levels
//     sw_clean  [WIDTH] debounced levels
//     sw_change [1]     one-cycle pulse after any sw_clean bit changed
//     sw_rise   [WIDTH] per-channel 0->1 pulse (SW_DEBOUNCE_EDGE_EN only)
//     sw_fall   [WIDTH] per-channel 1->0 pulse (SW_DEBOUNCE_EDGE_EN only)
//   Optional feature macro: SW_DEBOUNCE_EDGE_EN
// ---------------------------------------------------------------------------
interface switch_debounce_if #(
    parameter int unsigned WIDTH = 3
);
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] sw_clean;
    logic             sw_change;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    modport master (output switch, input sw_clean, input sw_change,
                    input sw_rise, input sw_fall);
    modport slave  (input switch, output sw_clean, output sw_change,
                    output sw_rise, output sw_fall);
`else
    modport master (output switch, input sw_clean, input sw_change);
    modport slave  (input switch, output sw_clean, output sw_change);
`endif
endinterface

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//   Synchronises and debounces WIDTH raw slide switches. Each channel passes
//   through a 2-flop synchroniser, a stability counter and a two-state FSM.
//   A new level is accepted only after CNT_MAX consecutive stable cycles.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : switch_debounce_if.slave (switch in; sw_clean/sw_change out)
//   Optional feature macro: SW_DEBOUNCE_EDGE_EN adds per-channel
//   sw_rise/sw_fall pulses that are coincident with sw_change.
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned CNT_MAX = 500000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debounce_if.slave    bus
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_clean_d;
    logic [WIDTH-1:0] w_clean_nxt;
    logic             r_change;
    state_t           r_state     [WIDTH];
    state_t           w_state_nxt [WIDTH];
    logic [CNT_W-1:0] r_cnt       [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
`endif

    // State register: synchroniser, per-channel FSM, clean levels, strobes.
    // The change strobe compares sw_clean with its one-cycle-delayed copy,
    // so it fires in the cycle after the edge that updated sw_clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_clean   <= '0;
            r_clean_d <= '0;
            r_change  <= 1'b0;
`ifdef SW_DEBOUNCE_EDGE_EN
            r_rise    <= '0;
            r_fall    <= '0;
`endif
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_s1      <= bus.switch;
            r_s2      <= r_s1;
            r_clean   <= w_clean_nxt;
            r_clean_d <= r_clean;
            r_change  <= |(r_clean ^ r_clean_d);
`ifdef SW_DEBOUNCE_EDGE_EN
            r_rise    <= r_clean & ~r_clean_d;
            r_fall    <= ~r_clean & r_clean_d;
`endif
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state logic, one independent FSM per channel.
    always_comb begin
        w_clean_nxt = r_clean;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    w_cnt_nxt[i] = '0;
                    if (r_s2[i] != r_clean[i]) begin
                        w_state_nxt[i] = ST_COUNTING;
                        w_cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ST_COUNTING: begin
                    if (r_s2[i] != r_clean[i]) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_clean_nxt[i] = r_s2[i];
                            w_cnt_nxt[i]   = '0;
                            w_state_nxt[i] = ST_STABLE;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                        end
                    end else begin
                        // Bounced back to the old level: abandon the count.
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_STABLE;
                    end
                end
                default: begin
                    w_cnt_nxt[i]   = '0;
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
        end
    end

    assign bus.sw_clean  = r_clean;
    assign bus.sw_change = r_change;
`ifdef SW_DEBOUNCE_EDGE_EN
    assign bus.sw_rise   = r_rise;
    assign bus.sw_fall   = r_fall;
`endif

endmodule
